// File: rtl/key_pkg.sv
// key_pkg: shared state type and priority encoder for the keypad front end
package key_pkg;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} key_state_t;

    localparam int ENC_MAX = 256;

    function automatic logic [7:0] prio_enc(input logic [ENC_MAX-1:0] v);
        prio_enc = '0;
        for (int i = ENC_MAX - 1; i >= 0; i--)
            if (v[i]) prio_enc = 8'(i);
    endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync: two-flop synchroniser for asynchronous key lines
module key_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // shift raw lines through two flops to settle metastability
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: debounce, priority-encode and strobe key presses with optional auto-repeat
module keypad_encoder
    import key_pkg::*;
#(
    parameter int NUM_KEYS    = 20,
    parameter int DB_CYCLES   = 4,
    parameter int REPEAT_EN   = 0,
    parameter int REPEAT_DLY  = 16,
    parameter int REPEAT_RATE = 8,
    localparam int CODE_W     = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] in,
    output logic [CODE_W-1:0]   out,
    output logic                strobe,
    output logic                held,
    output logic                multi
);

    localparam int MAX_AB = (DB_CYCLES > REPEAT_DLY) ? DB_CYCLES : REPEAT_DLY;
    localparam int MAX_C  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    logic [NUM_KEYS-1:0] s;
    logic [NUM_KEYS-1:0] cand;
    key_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    rpt;
    logic                rpt_first;
    logic [CNT_W-1:0]    rpt_nxt;
    logic                rpt_hit;
    logic [CODE_W-1:0]   code;

    key_sync #(.WIDTH(NUM_KEYS)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (in),
        .q  (s)
    );

    assign code    = CODE_W'(prio_enc(ENC_MAX'(cand)));
    assign rpt_nxt = rpt + 1'b1;
    assign rpt_hit = rpt_nxt == (rpt_first ? CNT_W'(REPEAT_DLY) : CNT_W'(REPEAT_RATE));

    // press/release debounce FSM; accept registers code and fires the strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            rpt       <= '0;
            rpt_first <= 1'b1;
            out       <= '0;
            strobe    <= 1'b0;
            held      <= 1'b0;
            multi     <= 1'b0;
        end else begin
            strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (s != '0) begin
                        state <= DEBOUNCE;
                        cand  <= s;
                        cnt   <= CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (s == '0) begin
                        state <= IDLE;
                    end else if (s != cand) begin
                        cand <= s;
                        cnt  <= CNT_W'(1);
                    end else if (cnt >= CNT_W'(DB_CYCLES - 1)) begin
                        state     <= PRESSED;
                        out       <= code;
                        multi     <= $countones(cand) > 1;
                        strobe    <= 1'b1;
                        held      <= 1'b1;
                        rpt       <= '0;
                        rpt_first <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (s != cand) begin
                        state <= RELEASE;
                        held  <= 1'b0;
                        cnt   <= '0;
                    end else if (REPEAT_EN != 0) begin
                        rpt <= rpt_hit ? '0 : rpt_nxt;
                        if (rpt_hit) begin
                            strobe    <= 1'b1;
                            rpt_first <= 1'b0;
                        end
                    end
                end
                RELEASE: begin
                    if (s != '0)
                        cnt <= '0;
                    else if (cnt >= CNT_W'(DB_CYCLES - 1))
                        state <= IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: sample-history model compared every cycle plus directed literal checks
module tb_keypad_encoder;

    localparam int NK = 20;
    localparam int DB = 4;
    localparam int RD = 16;
    localparam int RR = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] in;
    logic [4:0]    out_a, out_b;
    logic          strobe_a, held_a, multi_a;
    logic          strobe_b, held_b, multi_b;

    int total = 0;
    int pass  = 0;
    int cyc   = 0;
    int cnt_a = 0, cnt_b = 0, last_a = 0, last_b = 0;

    always #5 clk = ~clk;

    keypad_encoder #(.NUM_KEYS(NK), .DB_CYCLES(DB)) u_a (
        .clk(clk), .rst(rst), .in(in), .out(out_a),
        .strobe(strobe_a), .held(held_a), .multi(multi_a)
    );

    keypad_encoder #(.NUM_KEYS(NK), .DB_CYCLES(DB), .REPEAT_EN(1),
                     .REPEAT_DLY(RD), .REPEAT_RATE(RR)) u_b (
        .clk(clk), .rst(rst), .in(in), .out(out_b),
        .strobe(strobe_b), .held(held_b), .multi(multi_b)
    );

    typedef struct {
        logic [NK-1:0] s1, s2, last, key;
        int            run, zeros, h;
        bit            armed, pressed;
        int            out, strobe, held, multi;
    } mdl_t;

    mdl_t m[2];

    function automatic int lowest(input logic [NK-1:0] v);
        for (int i = 0; i < NK; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    // Model: a press is a run of DB identical non-zero synchronised samples while armed;
    // after a change from the held pattern, DB consecutive zero samples re-arm it.
    task automatic model_step(input int i, input bit rep);
        logic [NK-1:0] s;
        if (rst) begin
            m[i] = '{default: 0};
            m[i].armed = 1'b1;
        end else begin
            s = m[i].s2;
            m[i].s2 = m[i].s1;
            m[i].s1 = in;
            m[i].strobe = 0;
            if (m[i].armed) begin
                if (s == '0) m[i].run = 0;
                else if (s == m[i].last && m[i].run > 0) m[i].run++;
                else m[i].run = 1;
                m[i].last = s;
                if (m[i].run == DB) begin
                    m[i].key     = s;
                    m[i].out     = lowest(s);
                    m[i].multi   = ($countones(s) > 1) ? 1 : 0;
                    m[i].strobe  = 1;
                    m[i].held    = 1;
                    m[i].armed   = 1'b0;
                    m[i].pressed = 1'b1;
                    m[i].h       = 0;
                end
            end else if (m[i].pressed) begin
                if (s != m[i].key) begin
                    m[i].pressed = 1'b0;
                    m[i].held    = 0;
                    m[i].zeros   = 0;
                end else begin
                    m[i].h++;
                    if (rep && (m[i].h == RD || (m[i].h > RD && (m[i].h - RD) % RR == 0)))
                        m[i].strobe = 1;
                end
            end else begin
                m[i].zeros = (s == '0) ? m[i].zeros + 1 : 0;
                if (m[i].zeros == DB) begin
                    m[i].armed = 1'b1;
                    m[i].run   = 0;
                    m[i].last  = '0;
                end
            end
        end
    endtask

    // advance both models on every active edge
    always @(posedge clk) begin
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        cyc++;
    end

    // compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("a_out", int'(out_a), m[0].out);
            chk("a_strobe", int'(strobe_a), m[0].strobe);
            chk("a_held", int'(held_a), m[0].held);
            chk("a_multi", int'(multi_a), m[0].multi);
            chk("b_out", int'(out_b), m[1].out);
            chk("b_strobe", int'(strobe_b), m[1].strobe);
            chk("b_held", int'(held_b), m[1].held);
            chk("b_multi", int'(multi_b), m[1].multi);
            if (strobe_a === 1'b1) begin cnt_a++; last_a = cyc; end
            if (strobe_b === 1'b1) begin cnt_b++; last_b = cyc; end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int c0, c1, t0;
        rst = 1'b1;
        in  = '1;
        step(2);
        chk("t1_rst_out", int'(out_a), 0);
        chk("t1_rst_strobe", int'(strobe_a), 0);
        chk("t1_rst_held", int'(held_a), 0);
        chk("t1_rst_multi", int'(multi_a), 0);
        rst = 1'b0;
        in  = '0;
        c0  = cnt_a;
        step(10);
        chk("t1_no_strobe", cnt_a - c0, 0);

        c0 = cnt_a;
        t0 = cyc;
        in = NK'(1) << 13;
        step(20);
        chk("t2_count", cnt_a - c0, 1);
        chk("t2_latency", last_a - t0, 6);
        chk("t2_out", int'(out_a), 13);
        chk("t2_held", int'(held_a), 1);
        in = '0;
        step(3);
        chk("t2_held_drop", int'(held_a), 0);
        step(10);
        chk("t2_no_more", cnt_a - c0, 1);

        c0 = cnt_a;
        t0 = 0;
        for (int k = 0; k < 10; k++) begin
            in = (k % 4 < 2) ? NK'(1) << 7 : '0;
            if (k == 8) t0 = cyc;
            step(1);
        end
        step(12);
        chk("t3_count", cnt_a - c0, 1);
        chk("t3_latency", last_a - t0, 6);
        chk("t3_out", int'(out_a), 7);
        in = '0;
        step(10);

        in = (NK'(1) << 5) | (NK'(1) << 9);
        step(10);
        chk("t4_out_multi_key", int'(out_a), 5);
        chk("t4_multi_set", int'(multi_a), 1);
        in = '0;
        step(10);
        in = NK'(1) << 2;
        step(10);
        chk("t4_out_single", int'(out_a), 2);
        chk("t4_multi_clear", int'(multi_a), 0);
        in = '0;
        step(10);

        c0 = cnt_b;
        c1 = cnt_a;
        t0 = cyc;
        in = NK'(1) << 19;
        step(56);
        in = '0;
        step(10);
        chk("t5_rep_count", cnt_b - c0, 6);
        chk("t5_rep_last", last_b - t0, 6 + 48);
        chk("t5_rep_out", int'(out_b), 19);
        chk("t5_norep_count", cnt_a - c1, 1);

        c0 = cnt_a;
        in = NK'(1) << 3;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        in  = '0;
        step(10);
        chk("t6_rst_debounce", cnt_a - c0, 0);
        in = NK'(1) << 3;
        step(10);
        chk("t6_accept", cnt_a - c0, 1);
        chk("t6_held_before", int'(held_a), 1);
        rst = 1'b1;
        step(1);
        chk("t6_rst_held", int'(held_a), 0);
        chk("t6_rst_out", int'(out_a), 0);
        rst = 1'b0;
        in  = '0;
        step(10);
        chk("t6_after_rst", cnt_a - c0, 1);
        in = NK'(1) << 3;
        step(10);
        c1 = cnt_a;
        in = NK'(1) << 11;
        step(15);
        chk("t6_no_rollover", cnt_a - c1, 0);
        chk("t6_out_kept", int'(out_a), 3);
        in = '0;
        step(8);
        in = NK'(1) << 11;
        step(10);
        chk("t6_new_key", cnt_a - c1, 1);
        chk("t6_out_11", int'(out_a), 11);
        in = '0;
        step(10);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
